// File: rtl/mux4way_arb.sv
// Four-into-one valid/ready merger with a registered output stage and a 2-bit source tag.
// Define MUX4WAY_ARB_RR_EN for round-robin arbitration; otherwise channel 0 has fixed highest priority.
module mux4way_arb #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           in_valid,
    input  logic [4*WIDTH-1:0]   in_data,
    output logic [3:0]           in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [1:0]           out_sel,
    input  logic                 out_ready
);

    logic             out_valid_r;
    logic [WIDTH-1:0] out_data_r;
    logic [1:0]       out_sel_r;
    logic             load_s;
    logic [1:0]       start_s;
    logic [2:0]       grant_s;
    logic             grant_valid_s;
    logic [1:0]       grant_idx_s;
    logic [3:0]       in_ready_s;
    logic [WIDTH-1:0] grant_data_s;

    // Returns {found, index} of the first valid bit at or after start, wrapping 3 -> 0.
    // Scanning from the farthest offset down lets the nearest one overwrite the result.
    function automatic logic [2:0] pick_grant(input logic [3:0] valid, input logic [1:0] start);
        logic [2:0] result;
        logic [1:0] idx;
        result = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx    = start + 2'(k);
            result = valid[idx] ? {1'b1, idx} : result;
        end
        return result;
    endfunction

`ifdef MUX4WAY_ARB_RR_EN
    logic [1:0] last_r;

    // Round-robin pointer: remembers the most recently served channel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_r <= 2'd3;
        end else if (load_s && grant_valid_s) begin
            last_r <= grant_idx_s;
        end else begin
            last_r <= last_r;
        end
    end

    assign start_s = last_r + 2'd1;
`else
    assign start_s = 2'd0;
`endif

    assign load_s        = ~out_valid_r | out_ready;
    assign grant_s       = pick_grant(in_valid, start_s);
    assign grant_valid_s = grant_s[2];
    assign grant_idx_s   = grant_s[1:0];

    // Ready goes only to the granted channel, and only when the output stage can take a word.
    always_comb begin
        in_ready_s = 4'b0000;
        if (!reset && load_s && grant_valid_s) begin
            in_ready_s[grant_idx_s] = 1'b1;
        end else begin
            in_ready_s = 4'b0000;
        end
    end

    // Data of the granted channel, feeding only the output register.
    always_comb begin
        grant_data_s = '0;
        case (grant_idx_s)
            2'd0:    grant_data_s = in_data[0*WIDTH +: WIDTH];
            2'd1:    grant_data_s = in_data[1*WIDTH +: WIDTH];
            2'd2:    grant_data_s = in_data[2*WIDTH +: WIDTH];
            2'd3:    grant_data_s = in_data[3*WIDTH +: WIDTH];
            default: grant_data_s = '0;
        endcase
    end

    // Output stage: loads on a transfer, drains to empty when nothing is granted, holds under backpressure.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_sel_r   <= 2'b00;
        end else if (load_s) begin
            if (grant_valid_s) begin
                out_valid_r <= 1'b1;
                out_data_r  <= grant_data_s;
                out_sel_r   <= grant_idx_s;
            end else begin
                out_valid_r <= 1'b0;
                out_data_r  <= out_data_r;
                out_sel_r   <= out_sel_r;
            end
        end else begin
            out_valid_r <= out_valid_r;
            out_data_r  <= out_data_r;
            out_sel_r   <= out_sel_r;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_sel   = out_sel_r;

endmodule

// File: tb/tb_mux4way_arb.sv
// Directed bench for mux4way_arb: reset, single source, arbitration order, backpressure,
// wrap/skip, asynchronous reset mid-stream and an 8-bit instance.
module tb_mux4way_arb;

    logic        clk;
    logic        reset;
    logic [3:0]  in_valid;
    logic [63:0] in_data;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic [1:0]  out_sel;
    logic        out_ready;

    logic [3:0]  w8_in_valid;
    logic [31:0] w8_in_data;
    logic [3:0]  w8_in_ready;
    logic        w8_out_valid;
    logic [7:0]  w8_out_data;
    logic [1:0]  w8_out_sel;
    logic        w8_out_ready;

    int errors;
    int checks;

    typedef struct {
        logic [3:0]  valid;
        logic        rdy;
        logic [3:0]  exp_in_ready;
        logic        exp_ov;
        logic [15:0] exp_od;
        logic [1:0]  exp_os;
    } vec_t;

    vec_t vecs[19];

    mux4way_arb #(.WIDTH(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_sel(out_sel), .out_ready(out_ready)
    );

    mux4way_arb #(.WIDTH(8)) dut_w8 (
        .clk(clk), .reset(reset), .in_valid(w8_in_valid), .in_data(w8_in_data),
        .in_ready(w8_in_ready), .out_valid(w8_out_valid), .out_data(w8_out_data),
        .out_sel(w8_out_sel), .out_ready(w8_out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors       = 0;
        checks       = 0;
        reset        = 1'b1;
        in_valid     = 4'b1111;
        in_data      = 64'd0;
        out_ready    = 1'b1;
        w8_in_valid  = 4'b0000;
        w8_in_data   = 32'd0;
        w8_out_ready = 1'b1;

`ifdef MUX4WAY_ARB_RR_EN
        vecs[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 16'hAAAA, 2'd0};
        vecs[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 16'hBBBB, 2'd1};
        vecs[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 16'hCCCC, 2'd2};
        vecs[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 16'hDDDD, 2'd3};
        vecs[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 16'hAAAA, 2'd0};
        vecs[5]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 16'hBBBB, 2'd1};
        vecs[6]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 16'hCCCC, 2'd2};
        vecs[7]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 16'hDDDD, 2'd3};
        vecs[8]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 16'hDDDD, 2'd3};
        vecs[9]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 16'hDDDD, 2'd3};
        vecs[10] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 16'hDDDD, 2'd3};
        vecs[11] = '{4'b1111, 1'b1, 4'b0001, 1'b1, 16'hAAAA, 2'd0};
        vecs[12] = '{4'b0100, 1'b1, 4'b0100, 1'b1, 16'hCCCC, 2'd2};
        vecs[13] = '{4'b0011, 1'b1, 4'b0001, 1'b1, 16'hAAAA, 2'd0};
        vecs[14] = '{4'b0011, 1'b1, 4'b0010, 1'b1, 16'hBBBB, 2'd1};
`else
        vecs[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 16'hAAAA, 2'd0};
        vecs[1]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 16'hAAAA, 2'd0};
        vecs[2]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 16'hAAAA, 2'd0};
        vecs[3]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 16'hAAAA, 2'd0};
        vecs[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 16'hAAAA, 2'd0};
        vecs[5]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 16'hAAAA, 2'd0};
        vecs[6]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 16'hAAAA, 2'd0};
        vecs[7]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 16'hAAAA, 2'd0};
        vecs[8]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 16'hAAAA, 2'd0};
        vecs[9]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 16'hAAAA, 2'd0};
        vecs[10] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 16'hAAAA, 2'd0};
        vecs[11] = '{4'b1111, 1'b1, 4'b0001, 1'b1, 16'hAAAA, 2'd0};
        vecs[12] = '{4'b0100, 1'b1, 4'b0100, 1'b1, 16'hCCCC, 2'd2};
        vecs[13] = '{4'b0011, 1'b1, 4'b0001, 1'b1, 16'hAAAA, 2'd0};
        vecs[14] = '{4'b0011, 1'b1, 4'b0001, 1'b1, 16'hAAAA, 2'd0};
`endif
        vecs[15] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 16'h0000, 2'd0};
        vecs[16] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 16'h0000, 2'd0};
        vecs[17] = '{4'b1000, 1'b0, 4'b1000, 1'b1, 16'hDDDD, 2'd3};
        vecs[18] = '{4'b0010, 1'b1, 4'b0010, 1'b1, 16'hBBBB, 2'd1};

        // Reset state, with all sources requesting.
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_out_sel",   32'(out_sel),   32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        tick();
        reset = 1'b0;

        // Single source on channel b.
        in_valid  = 4'b0010;
        in_data   = {16'h0000, 16'h0000, 16'h1234, 16'h0000};
        out_ready = 1'b1;
        #1;
        chk("single_in_ready", 32'(in_ready), 32'b0010);
        tick();
        chk("single_out_valid", 32'(out_valid), 32'd1);
        chk("single_out_data",  32'(out_data),  32'h1234);
        chk("single_out_sel",   32'(out_sel),   32'd1);
        in_valid = 4'b0000;
        #1;
        chk("single_idle_in_ready", 32'(in_ready), 32'd0);
        tick();
        chk("single_idle_out_valid", 32'(out_valid), 32'd0);

        // Fresh reset so the pointer starts at 3 for the table.
        reset = 1'b1;
        #2;
        reset = 1'b0;
        in_data = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};

        for (int i = 0; i < 19; i++) begin
            in_valid  = vecs[i].valid;
            out_ready = vecs[i].rdy;
            #1;
            chk($sformatf("row%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].exp_in_ready));
            tick();
            chk($sformatf("row%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ov));
            if (vecs[i].exp_ov) begin
                chk($sformatf("row%0d_out_data", i), 32'(out_data), 32'(vecs[i].exp_od));
                chk($sformatf("row%0d_out_sel", i),  32'(out_sel),  32'(vecs[i].exp_os));
            end
        end

        // Asynchronous reset between edges while a word (BBBB, sel 01) is pending.
        #2;
        reset     = 1'b1;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        #1;
        chk("async_out_valid", 32'(out_valid), 32'd0);
        chk("async_out_data",  32'(out_data),  32'd0);
        chk("async_out_sel",   32'(out_sel),   32'd0);
        chk("async_in_ready",  32'(in_ready),  32'd0);
        #1;
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'b0001);
        tick();
        chk("post_rst_out_valid", 32'(out_valid), 32'd1);
        chk("post_rst_out_data",  32'(out_data),  32'hAAAA);
        chk("post_rst_out_sel",   32'(out_sel),   32'd0);

        // 8-bit instance, channel d.
        w8_in_valid = 4'b1000;
        w8_in_data  = {8'h5A, 8'h11, 8'h22, 8'h33};
        #1;
        chk("w8_in_ready", 32'(w8_in_ready), 32'b1000);
        tick();
        chk("w8_out_valid", 32'(w8_out_valid), 32'd1);
        chk("w8_out_data",  32'(w8_out_data),  32'h5A);
        chk("w8_out_sel",   32'(w8_out_sel),   32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux4way_arb.md
Name: mux4way_arb

Overview:
- Converging counterpart of the 4-way demultiplexer: merges four 16-bit valid/ready source channels onto one output channel.
- Reports which source won on a 2-bit sel tag, using the same encoding the demux consumes. A downstream demux can therefore route words back by sel.
- Single registered output stage; full throughput of one word per cycle.
- Used wherever several producers share one consumer, e.g. a bus or memory-port front end.

Parameters:
- WIDTH, 16, data width of every channel.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  4  per-channel valid; bit i belongs to channel i.
- in_data  input  4*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  4  per-channel ready; one-hot or zero.
- out_valid  output  1  output word valid.
- out_data  output  WIDTH  output word.
- out_sel  output  2  index of the channel that produced out_data (00=a, 01=b, 10=c, 11=d).
- out_ready  input  1  consumer ready.

Behaviour:
- Reset values (asynchronous, effective immediately):
  - out_valid=0, out_data=0, out_sel=00.
  - Round-robin pointer last=3, so channel 0 has first priority after reset.
  - in_ready=0 while reset is high.
- Load enable: load = ~out_valid | out_ready. This is combinational, and there is no combinational path from in_data to out_data.
- Arbitration (combinational, every cycle):
  - Search in_valid starting at (last+1) mod 4, wrapping through 3→0.
  - The first set bit is the grant g.
  - If no bit is set, there is no grant.
- Handshake:
  - in_ready[g] = load & in_valid[g]; all other in_ready bits = 0.
  - A transfer on channel g occurs when in_valid[g] & in_ready[g].
- On the clock edge when a channel transfers:
  - out_data <= channel g data, out_sel <= g, out_valid <= 1, last <= g.
- On a clock edge with load=1 and no grant: out_valid <= 0. out_data and out_sel hold their previous values and are don't-care.
- Backpressure: while out_valid=1 and out_ready=0:
  - out_data, out_sel and out_valid hold stable.
  - All in_ready bits are 0 and last does not change.
- Latency: a word accepted at edge N appears on out_* immediately after edge N, i.e. in cycle N+1.
- Back-to-back transfers: if out_valid=1, out_ready=1 and a grant exists in the same cycle, the old word drains and the new word loads on the same edge. There is no bubble.
- Fairness: with all four channels continuously valid and out_ready=1, the grant order is 0,1,2,3,0,... Each channel waits at most 3 grants.
- A source that deasserts valid before it is granted is simply skipped. The pointer only moves on an actual transfer.
- Reset mid-operation: a pending output word is discarded (out_valid→0) and the pointer returns to 3. No partial state survives.
- Inputs sampled while in_ready=0 have no effect.

Optional Feature:
- Macro: MUX4WAY_ARB_RR_EN.
- Defined: round-robin arbitration exactly as above.
- Not defined: fixed priority, channel 0 highest and channel 3 lowest.
  - The last register is not implemented.
  - The grant is the lowest-index valid bit.
  - All other behaviour (handshake, backpressure, latency, reset) is identical.

Test Plan:
- Reset, then single source: reset pulse; in_valid=0010, in_data[b]=16'h1234, out_ready=1 → in_ready=0010. After the next edge: out_valid=1, out_data=16'h1234, out_sel=01. The following cycle with in_valid=0: out_valid=0.
- Round-robin (RR_EN): all in_valid=1111 with data a=16'hAAAA, b=16'hBBBB, c=16'hCCCC, d=16'hDDDD, out_ready=1 for 8 cycles → out_sel sequence 00,01,10,11,00,01,10,11, data matching, no idle cycles. Without the macro: out_sel stays 00 every cycle.
- Backpressure: out_valid=1 with out_data=16'h00FF; hold out_ready=0 for 3 cycles with in_valid=1111 → in_ready=0000 and out_data, out_sel unchanged. Release out_ready=1 → next word loads on the same edge, out_sel advances by one.
- Wrap and skip: last=2, in_valid=0011 → grant 0 (3 is skipped, wraps to 0), out_sel=00. Next grant is 1.
- Async reset mid-stream: assert reset between clock edges while out_valid=1 → out_valid=0, out_data=0, out_sel=00 without waiting for clk. After release with in_valid=1111 → first out_sel=00.
- Width check: instantiate WIDTH=8; channel d data=8'h5A → out_data=8'h5A, out_sel=11.
